// File: rtl/sram_like_bridge_pkg.sv
// Shared definitions for the sram-like memory bridge: FSM encoding,
// transfer size codes and the kseg0/kseg1 segment-stripping constant.
package sram_like_bridge_pkg;

  // Bridge FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Transfer size codes as driven on cpu_size / size
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Value forced into addr[31:29] for unmapped kseg0/kseg1 windows
  localparam logic [2:0] KSEG_MASK = 3'b000;

  // True for the 0x8000_0000..0xBFFF_FFFF window (kseg0 and kseg1)
  function automatic logic is_kseg01(input logic [1:0] top_bits);
    return (top_bits == 2'b10);
  endfunction

endpackage

// File: rtl/sram_like_bridge_xlate.sv
// Fixed-mapping address translation: kseg0/kseg1 addresses lose their
// segment bits, everything else passes through. Purely combinational.
module mmu_fixed_xlate
  import sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter bit TRANSLATE = 1'b1
) (
  input  logic [ADDR_W-1:0] vaddr,
  output logic [ADDR_W-1:0] paddr
);

  generate
    if (TRANSLATE && (ADDR_W >= 32)) begin : g_xlate
      // Strip bits [31:29] when the address falls in kseg0/kseg1
      always_comb begin
        paddr = vaddr;
        if (is_kseg01(vaddr[31:30])) begin
          paddr[31:29] = KSEG_MASK;
        end else begin
          paddr = vaddr;
        end
      end
    end else begin : g_pass
      assign paddr = vaddr;
    end
  endgenerate

endmodule

// File: rtl/sram_like_bridge.sv
// Converts a single-cycle CPU memory port into a handshaked sram-like
// master (req/addr_ok/data_ok). Stalls the pipeline while a transaction
// is outstanding and swallows the response of accesses flushed after
// the slave accepted them.
module sram_like_bridge
  import sram_like_bridge_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter bit TRANSLATE = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [1:0]          cpu_size,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_flush,
  input  logic                cpu_hold,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata
);

  logic [1:0]        state_r;
  logic [1:0]        next_state_s;
  logic              discard_r;
  logic              start_s;
  logic              load_s;
  logic [ADDR_W-1:0] paddr_s;

  // Translation happens before latching so addr is frozen while req=1
  mmu_fixed_xlate #(
    .ADDR_W   (ADDR_W),
    .TRANSLATE(TRANSLATE)
  ) u_xlate (
    .vaddr(cpu_addr),
    .paddr(paddr_s)
  );

  // Handshake conditions: new access accepted from the pipeline, and read data to keep
  always_comb begin
    start_s = (state_r == ST_IDLE) && cpu_en && !cpu_flush;
    if (state_r == ST_DATA) begin
      load_s = data_ok && !discard_r && !cpu_flush && !wr;
    end else begin
      load_s = 1'b0;
    end
  end

  // Next-state decode; data_ok only matters in DATA, accepted accesses always complete
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) next_state_s = ST_ADDR;
        else         next_state_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (addr_ok)        next_state_s = ST_DATA;
        else if (cpu_flush) next_state_s = ST_IDLE;
        else                next_state_s = ST_ADDR;
      end
      ST_DATA: begin
        if (!data_ok)                     next_state_s = ST_DATA;
        else if (discard_r || cpu_flush)  next_state_s = ST_IDLE;
        else                              next_state_s = ST_DONE;
      end
      ST_DONE: begin
        if (!cpu_hold || cpu_flush) next_state_s = ST_IDLE;
        else                        next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Pipeline stall: from the first request cycle until the response arrives
  always_comb begin
    cpu_stall = 1'b0;
    case (state_r)
      ST_IDLE: cpu_stall = cpu_en & ~cpu_flush;
      ST_ADDR: cpu_stall = 1'b1;
      ST_DATA: cpu_stall = 1'b1;
      ST_DONE: cpu_stall = 1'b0;
      default: cpu_stall = 1'b0;
    endcase
  end

  // FSM state and the flag marking an accepted access whose result must be dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      discard_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        ST_ADDR: discard_r <= addr_ok & cpu_flush;
        ST_DATA: discard_r <= data_ok ? 1'b0 : (discard_r | cpu_flush);
        default: discard_r <= 1'b0;
      endcase
    end
  end

  // Registered bus request, high exactly while the FSM sits in ADDR
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req <= 1'b0;
    end else begin
      req <= (next_state_s == ST_ADDR);
    end
  end

  // Capture the access attributes once, when the request is first accepted from the CPU
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr    <= 1'b0;
      size  <= SZ_B;
      addr  <= '0;
      wdata <= '0;
    end else if (start_s) begin
      wr    <= |cpu_wen;
      size  <= cpu_size;
      addr  <= paddr_s;
      wdata <= cpu_wdata;
    end else begin
      wr    <= wr;
      size  <= size;
      addr  <= addr;
      wdata <= wdata;
    end
  end

  // Load data register: updated only by a completed, non-discarded read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cpu_rdata <= '0;
    end else if (load_s) begin
      cpu_rdata <= rdata;
    end else begin
      cpu_rdata <= cpu_rdata;
    end
  end

endmodule

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
- Next-generation memory port for the CPU top level. It replaces the current single-cycle SRAM port (en/wen/addr/wdata/rdata) with a handshaked sram-like master (req/addr_ok/data_ok).
- It produces a pipeline stall while a transaction is outstanding, and absorbs exception flushes.
- Data width, address width and kseg0/kseg1 translation are parametrised.
- One instance is used for the instruction port and one for the data port.

Parameters:
- DATA_W, 32, data bus width; must be 32 or 64.
- ADDR_W, 32, address width.
- TRANSLATE, 1, when 1, addresses with addr[31:30]==2'b10 (kseg0/kseg1) have bits [31:29] cleared; when 0, addresses pass through unchanged.

Ports:
- clk  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- cpu_en  in  1  access request from the pipeline; held stable until cpu_stall drops.
- cpu_wen  in  DATA_W/8  byte write enables; all-zero means read.
- cpu_size  in  2  0=byte, 1=half, 2=word, 3=dword (dword only legal when DATA_W=64).
- cpu_addr  in  ADDR_W  virtual address.
- cpu_wdata  in  DATA_W  store data.
- cpu_flush  in  1  exception flush; abandons the current access.
- cpu_hold  in  1  pipeline frozen by another source; the result must be held.
- cpu_rdata  out  DATA_W  registered load data.
- cpu_stall  out  1  pipeline must stall.
- req  out  1  bus request.
- wr  out  1  1=write.
- size  out  2  transfer size.
- addr  out  ADDR_W  physical address.
- wdata  out  DATA_W  write data.
- addr_ok  in  1  slave accepted the request this cycle.
- data_ok  in  1  read data valid / write complete this cycle.
- rdata  in  DATA_W  read data.

Behaviour:
- Reset values (async on resetn low): state=IDLE, and req, wr, size, addr, wdata, cpu_rdata all 0. Any outstanding bus transaction is dropped; the slave shares the same reset.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - cpu_en=1 and cpu_flush=0 -> latch wr=|cpu_wen, size=cpu_size, addr=xlate(cpu_addr), wdata=cpu_wdata; next state ADDR.
  - cpu_stall=cpu_en combinationally, so a request stalls the pipeline from its first cycle.
- ADDR:
  - req=1, with wr/size/addr/wdata stable from their registers.
  - addr_ok=1 -> DATA; req deasserts in the next cycle.
  - cpu_flush=1 with addr_ok=0 -> IDLE and req withdrawn. This is legal because the request was never accepted.
  - cpu_flush=1 with addr_ok=1 -> DATA with discard flag set.
- DATA:
  - req=0. data_ok is sampled only in this state; data_ok in ADDR or IDLE is ignored as a protocol violation.
  - data_ok=1, discard=0 -> cpu_rdata<=rdata (reads only; writes leave cpu_rdata unchanged); next state DONE.
  - data_ok=1, discard=1 -> IDLE, cpu_rdata unchanged.
  - cpu_flush in DATA sets discard. The bridge always waits for data_ok and never abandons an accepted transaction.
- DONE:
  - cpu_stall=0 and cpu_rdata is held.
  - cpu_hold=0 or cpu_flush=1 -> IDLE.
  - Otherwise stay, so the same access is not reissued while the pipeline is frozen.
- cpu_stall = (state==IDLE & cpu_en & ~cpu_flush) | state==ADDR | state==DATA.
- Minimum latency, read with addr_ok and data_ok each 1 cycle after req: 3 cycles from cpu_en to cpu_stall low.
- Translation: performed in the bridge, combinationally on cpu_addr before it is latched, so addr never changes while req=1.
- Alignment is not checked here; the pipeline raises address exceptions before cpu_en.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, ADDR=2'd1, DATA=2'd2, DONE=2'd3;
  - size constants SZ_B/SZ_H/SZ_W/SZ_D;
  - KSEG mask 3'b000 for bits [31:29].
- One sub-module, mmu_fixed_xlate: purely combinational, parametrised by ADDR_W and TRANSLATE.

Test Plan:
1. Read 0xBFC00000, addr_ok +1 cycle, data_ok +1 cycle, rdata=0x3C08BFC0 -> addr=0x1FC00000, wr=0, size=2, cpu_rdata=0x3C08BFC0, cpu_stall high exactly 3 cycles.
2. Byte store cpu_wen=4'b0100, addr 0x80001002, data 0x00AB0000, addr_ok held low 4 cycles -> req high 5 cycles, addr=0x00001002, size=0, wr=1, wdata stable throughout.
3. cpu_flush in ADDR before addr_ok -> req drops the next cycle, state IDLE, no data_ok expected, cpu_rdata unchanged.
4. cpu_flush in DATA, data_ok 2 cycles later with rdata=0xDEADBEEF -> cpu_rdata keeps its old value, state IDLE, no DONE.
5. cpu_hold=1 for 3 cycles after DONE -> no new req, cpu_rdata held; first req only after cpu_hold=0.
6. resetn low while in DATA -> req=0, cpu_stall=0, cpu_rdata=0 immediately, without waiting for a clock edge; a read with TRANSLATE=0 after reset gives addr equal to cpu_addr.
